// File: rtl/mw_writeback_stage_if.sv
// M-stage to W-stage bundle: the instruction fields leaving the data-memory
// stage together with its address-error flag.
//   master : data-memory stage side (drives everything)
//   slave  : writeback stage side (samples everything)
interface mw_writeback_stage_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        m_stat;
  logic [3:0]        m_icode;
  logic [DATA_W-1:0] m_valE;
  logic [DATA_W-1:0] m_valM;
  logic [3:0]        m_dstE;
  logic [3:0]        m_dstM;
  logic              mem_error;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, mem_error
  );

  modport slave (
    input m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, mem_error
  );
endinterface

// File: rtl/mw_writeback_stage.sv
// Memory-to-writeback pipeline register, architectural register file and
// processor status tracker.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m                   M-stage bundle (stat, icode, valE, valM, dstE, dstM, mem_error)
//   W_stall, W_bubble   W register hold / bubble insert (bubble wins)
//   srcA, srcB          decode read indices; valA_rd / valB_rd combinational data
//   W_*                 W register contents (forwarding sources)
//   cpu_stat, halted    architectural status, high once status leaves AOK
//   retired             committed non-nop instruction count (wraps)
//
// State | meaning
// RUN   | committing instructions from W
// HALT  | halt instruction reached W, absorbing until reset
// FAULT | ADR or INS reached W, absorbing until reset
module mw_writeback_stage #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = 64'd0,
  parameter int                CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mw_writeback_stage_if.slave m,
  input  logic                W_stall,
  input  logic                W_bubble,
  input  logic [3:0]          srcA,
  input  logic [3:0]          srcB,
  output logic [DATA_W-1:0]   valA_rd,
  output logic [DATA_W-1:0]   valB_rd,
  output logic [3:0]          W_stat,
  output logic [3:0]          W_icode,
  output logic [3:0]          W_dstE,
  output logic [3:0]          W_dstM,
  output logic [DATA_W-1:0]   W_valE,
  output logic [DATA_W-1:0]   W_valM,
  output logic [3:0]          cpu_stat,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_NONE  = 4'hF;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]        state;
  logic              counted;
  logic              w_load;
  logic              wb_en;
  logic              count_en;
  logic [DATA_W-1:0] regs [0:15];

  // Any bubble or fresh load brings a new instruction into W.
  assign w_load   = W_bubble | ~W_stall;
  assign wb_en    = (state == ST_RUN) && (W_stat == STAT_AOK);
  assign count_en = wb_en && (W_icode != ICODE_NOP) && !counted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= STAT_AOK;
      W_icode <= ICODE_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else if (W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= ICODE_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= REG_NONE;
      W_dstM  <= REG_NONE;
    end else if (!W_stall) begin
      W_stat  <= (m.mem_error && m.m_stat == STAT_AOK) ? STAT_ADR : m.m_stat;
      W_icode <= m.m_icode;
      W_valE  <= m.m_valE;
      W_valM  <= m.m_valM;
      W_dstE  <= m.m_dstE;
      W_dstM  <= m.m_dstM;
    end
  end

  // Entry 15 exists only so every 4-bit index is in range; it is never
  // written and the read muxes force it to zero anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= (i == 4) ? RSP_RESET : '0;
      end
    end else if (wb_en) begin
      if (W_dstE != REG_NONE) regs[W_dstE] <= W_valE;
      // Later assignment wins, so valM takes priority when dstE == dstM.
      if (W_dstM != REG_NONE) regs[W_dstM] <= W_valM;
    end
  end

  assign valA_rd = (srcA == REG_NONE) ? '0 : regs[srcA];
  assign valB_rd = (srcB == REG_NONE) ? '0 : regs[srcB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cpu_stat <= STAT_AOK;
      halted   <= 1'b0;
    end else if (state == ST_RUN) begin
      case (W_stat)
        STAT_HLT: begin
          state    <= ST_HALT;
          cpu_stat <= STAT_HLT;
          halted   <= 1'b1;
        end
        STAT_ADR, STAT_INS: begin
          state    <= ST_FAULT;
          cpu_stat <= W_stat;
          halted   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A stalled instruction stays in W for several edges; the flag makes it
  // count once and is cleared whenever W takes a new instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
      counted <= 1'b0;
    end else begin
      if (count_en) retired <= retired + CNT_W'(1);
      if (w_load) counted <= 1'b0;
      else if (count_en) counted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mw_writeback_stage.sv
module tb_mw_writeback_stage;

  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_FF00;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
  } winstr_t;

  logic        clk;
  logic        rst_n;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA_rd;
  logic [63:0] valB_rd;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  cpu_stat;
  logic        halted;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state as plain variables.
  logic [63:0] mregs [0:15];
  winstr_t     mw;
  logic        mseen;
  logic [3:0]  mcpu;
  logic [31:0] mret;

  mw_writeback_stage_if #(.DATA_W(64)) mif ();

  mw_writeback_stage #(
    .DATA_W(64), .RSP_RESET(RSP_INIT), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m(mif.slave),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .srcA(srcA), .srcB(srcB), .valA_rd(valA_rd), .valB_rd(valB_rd),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .cpu_stat(cpu_stat), .halted(halted), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic winstr_t bubble_instr();
    winstr_t b;
    b.stat = 4'd1; b.icode = 4'h1; b.dstE = 4'hF; b.dstM = 4'hF;
    b.valE = '0;   b.valM = '0;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = (i == 4) ? RSP_INIT : 64'd0;
    mw    = bubble_instr();
    mseen = 1'b0;
    mcpu  = 4'd1;
    mret  = 0;
  endtask

  // What one clock edge does to the architectural state, given current inputs.
  task automatic model_edge();
    winstr_t nxt;
    if (mcpu == 4'd1 && mw.stat == 4'd1) begin
      if (mw.dstE != 4'hF) mregs[mw.dstE] = mw.valE;
      if (mw.dstM != 4'hF) mregs[mw.dstM] = mw.valM;
      if (mw.icode != 4'h1 && !mseen) begin
        mret  = mret + 1;
        mseen = 1'b1;
      end
    end else if (mcpu == 4'd1) begin
      mcpu = mw.stat;
    end
    if (W_bubble) begin
      mw = bubble_instr();
      mseen = 1'b0;
    end else if (!W_stall) begin
      nxt.stat  = (mif.mem_error && mif.m_stat == 4'd1) ? 4'd3 : mif.m_stat;
      nxt.icode = mif.m_icode;
      nxt.dstE  = mif.m_dstE;
      nxt.dstM  = mif.m_dstM;
      nxt.valE  = mif.m_valE;
      nxt.valM  = mif.m_valM;
      mw = nxt;
      mseen = 1'b0;
    end
  endtask

  task automatic drive_m(input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic err);
    mif.m_stat = st; mif.m_icode = ic; mif.m_valE = ve; mif.m_valM = vm;
    mif.m_dstE = de; mif.m_dstM = dm; mif.mem_error = err;
  endtask

  task automatic drive_nop();
    drive_m(4'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    W_stall = 1'b0; W_bubble = 1'b0; srcA = 4'hF; srcB = 4'hF;
    drive_nop();
    @(negedge clk);
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    srcA = 4'd4; srcB = 4'd0; #1;
    checks++;
    if (valA_rd !== RSP_INIT) begin errors++; $display("FAIL reset_rsp got %h want %h", valA_rd, RSP_INIT); end
    checks++;
    if (valB_rd !== 64'd0) begin errors++; $display("FAIL reset_r0 got %h want 0", valB_rd); end
    checks++;
    if (cpu_stat !== 4'd1 || halted !== 1'b0) begin errors++; $display("FAIL reset_stat got %0d/%0b want 1/0", cpu_stat, halted); end
    checks++;
    if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++;
    if (W_icode !== 4'h1 || W_stat !== 4'd1 || W_dstE !== 4'hF || W_dstM !== 4'hF)
      begin errors++; $display("FAIL reset_w got icode %h stat %h dstE %h dstM %h want 1 1 F F", W_icode, W_stat, W_dstE, W_dstM); end
    srcA = 4'hF; #1;
    checks++;
    if (valA_rd !== 64'd0) begin errors++; $display("FAIL read_F got %h want 0", valA_rd); end
  endtask

  task automatic test_irmovq();
    drive_m(4'd1, 4'h3, 64'h2A, 64'd0, 4'd2, 4'hF, 1'b0);
    tick();
    drive_nop();
    srcA = 4'd2; #1;
    checks++;
    if (W_icode !== 4'h3 || W_valE !== 64'h2A) begin errors++; $display("FAIL irmovq_wreg got icode %h valE %h want 3 2a", W_icode, W_valE); end
    checks++;
    if (valA_rd !== 64'd0) begin errors++; $display("FAIL irmovq_write_cycle got %h want 0", valA_rd); end
    tick();
    checks++;
    if (valA_rd !== 64'h2A) begin errors++; $display("FAIL irmovq_commit got %h want 2a", valA_rd); end
    checks++;
    if (retired !== 32'd1 || retired !== mret) begin errors++; $display("FAIL irmovq_retired got %0d want 1", retired); end
  endtask

  task automatic test_popq_priority();
    drive_m(4'd1, 4'hB, 64'h10, 64'h55, 4'd4, 4'd4, 1'b0);
    tick();
    drive_nop();
    checks++;
    if (W_valM !== 64'h55 || W_dstM !== 4'd4) begin errors++; $display("FAIL popq_fwd got valM %h dstM %h want 55 4", W_valM, W_dstM); end
    tick();
    srcB = 4'd4; #1;
    checks++;
    if (valB_rd !== 64'h55) begin errors++; $display("FAIL popq_valM_wins got %h want 55", valB_rd); end
  endtask

  task automatic test_stall();
    logic [31:0] base;
    base = mret;
    drive_m(4'd1, 4'h6, 64'h77, 64'd0, 4'd5, 4'hF, 1'b0);
    tick();
    W_stall = 1'b1;
    drive_m(4'd1, 4'h3, 64'h99, 64'd0, 4'd7, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (W_icode !== 4'h6 || W_dstE !== 4'd5) begin errors++; $display("FAIL stall_hold[%0d] got icode %h dstE %h want 6 5", i, W_icode, W_dstE); end
      checks++;
      if (retired !== base + 32'd1) begin errors++; $display("FAIL stall_retired[%0d] got %0d want %0d", i, retired, base + 32'd1); end
    end
    srcA = 4'd5; srcB = 4'd7; #1;
    checks++;
    if (valA_rd !== 64'h77 || valB_rd !== 64'd0) begin errors++; $display("FAIL stall_regs got r5 %h r7 %h want 77 0", valA_rd, valB_rd); end
    W_bubble = 1'b1;
    tick();
    checks++;
    if (W_icode !== 4'h1 || W_dstE !== 4'hF || W_valE !== 64'd0) begin errors++; $display("FAIL stall_bubble got icode %h dstE %h want 1 F", W_icode, W_dstE); end
    W_stall = 1'b0; W_bubble = 1'b0;
    drive_nop();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive_m(4'd1, 4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      W_stall  = ($urandom_range(0, 4) == 0);
      W_bubble = ($urandom_range(0, 9) == 0);
      tick();
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (W_icode !== mw.icode || W_valE !== mw.valE || W_valM !== mw.valM || W_dstE !== mw.dstE)
        begin errors++; $display("FAIL rand_w[%0d] got icode %h valE %h want %h %h", n, W_icode, W_valE, mw.icode, mw.valE); end
      checks++;
      if (valA_rd !== mregs[srcA] || valB_rd !== mregs[srcB])
        begin errors++; $display("FAIL rand_read[%0d] got %h %h want %h %h", n, valA_rd, valB_rd, mregs[srcA], mregs[srcB]); end
      checks++;
      if (retired !== mret || cpu_stat !== mcpu)
        begin errors++; $display("FAIL rand_status[%0d] got ret %0d stat %0d want %0d %0d", n, retired, cpu_stat, mret, mcpu); end
    end
    W_stall = 1'b0; W_bubble = 1'b0;
  endtask

  task automatic test_mem_fault();
    logic [31:0] base;
    logic [63:0] r3;
    apply_reset();
    base = mret;
    r3 = mregs[3];
    drive_m(4'd1, 4'h5, 64'h8, 64'h123, 4'hF, 4'd3, 1'b1);
    tick();
    checks++;
    if (W_stat !== 4'd3) begin errors++; $display("FAIL adr_wstat got %0d want 3", W_stat); end
    drive_m(4'd1, 4'h3, 64'h999, 64'd0, 4'd3, 4'hF, 1'b0);
    tick();
    checks++;
    if (cpu_stat !== 4'd3 || halted !== 1'b1) begin errors++; $display("FAIL adr_cpu got %0d/%0b want 3/1", cpu_stat, halted); end
    drive_nop();
    tick(); tick();
    srcA = 4'd3; #1;
    checks++;
    if (valA_rd !== r3) begin errors++; $display("FAIL adr_no_write got %h want %h", valA_rd, r3); end
    checks++;
    if (retired !== base || cpu_stat !== mcpu) begin errors++; $display("FAIL adr_frozen got ret %0d stat %0d want %0d %0d", retired, cpu_stat, base, mcpu); end
  endtask

  task automatic test_halt_reset();
    apply_reset();
    drive_m(4'd2, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
    tick();
    drive_m(4'd1, 4'h3, 64'h66, 64'd0, 4'd6, 4'hF, 1'b0);
    tick();
    checks++;
    if (cpu_stat !== 4'd2 || halted !== 1'b1) begin errors++; $display("FAIL hlt_cpu got %0d/%0b want 2/1", cpu_stat, halted); end
    drive_nop();
    tick(); tick();
    srcA = 4'd6; #1;
    checks++;
    if (valA_rd !== 64'd0) begin errors++; $display("FAIL hlt_no_write got %h want 0", valA_rd); end
    // Mid-cycle asynchronous reset: state must clear with no clock edge.
    #2;
    rst_n = 1'b0;
    srcA = 4'd4;
    #1;
    checks++;
    if (cpu_stat !== 4'd1 || halted !== 1'b0 || retired !== 32'd0 || W_icode !== 4'h1)
      begin errors++; $display("FAIL async_reset got stat %0d halted %0b ret %0d icode %h want 1 0 0 1", cpu_stat, halted, retired, W_icode); end
    checks++;
    if (valA_rd !== RSP_INIT) begin errors++; $display("FAIL async_reset_rsp got %h want %h", valA_rd, RSP_INIT); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_irmovq();
    test_popq_priority();
    test_stall();
    test_random();
    test_mem_fault();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
